// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply modular exponentiation controller.
// Drives an external en/valid modular multiplier; holds no multiplier itself.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; latches operands on accept
// ST_SCAN   | shifting exponent left until its MSB is 1
// ST_REDUCE | issue base x 1 -> base_r, acc = base_r, consume MSB
// ST_SQR    | issue acc x acc -> acc
// ST_MUL    | issue acc x base_r -> acc (current exponent bit is 1)
// ST_NEXT   | shift exponent, decrement remaining-bit counter
// ST_FIN    | load result/err, raise done on the next cycle
// ST_DONE   | done pulse cycle; busy still high, returns to IDLE
module mod_exp_ctrl #(
  parameter int WIDTH     = 256,
  parameter int EXP_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy,
  output logic                 err,
  output logic                 mul_en,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic [WIDTH-1:0]     mul_n,
  input  logic [WIDTH-1:0]     mul_r,
  input  logic                 mul_valid
);

  localparam int CW = $clog2(EXP_WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE, ST_SCAN, ST_REDUCE, ST_SQR, ST_MUL, ST_NEXT, ST_FIN, ST_DONE
  } state_t;

  state_t               r_state, w_state_n;
  logic                 r_rel, w_rel_n;
  logic [EXP_WIDTH-1:0] r_exp, w_exp_n;
  logic [CW-1:0]        r_cnt, w_cnt_n;
  logic [WIDTH-1:0]     r_acc, w_acc_n;
  logic [WIDTH-1:0]     r_base, w_base_n;
  logic                 r_err_pend, w_err_pend_n;
  logic [WIDTH-1:0]     r_result, w_result_n;
  logic                 r_done, w_done_n;
  logic                 r_busy, w_busy_n;
  logic                 r_err, w_err_n;
  logic                 r_mul_en, w_mul_en_n;
  logic [WIDTH-1:0]     r_mul_a, w_mul_a_n;
  logic [WIDTH-1:0]     r_mul_b, w_mul_b_n;
  logic [WIDTH-1:0]     r_mul_n, w_mul_n_n;

  logic [WIDTH-1:0]     w_op_a, w_op_b;
  logic                 w_is_op;

  assign result = r_result;
  assign done   = r_done;
  assign busy   = r_busy;
  assign err    = r_err;
  assign mul_en = r_mul_en;
  assign mul_a  = r_mul_a;
  assign mul_b  = r_mul_b;
  assign mul_n  = r_mul_n;

  assign w_is_op = (r_state == ST_REDUCE) || (r_state == ST_SQR) || (r_state == ST_MUL);
  assign w_op_a  = (r_state == ST_REDUCE) ? r_base : r_acc;
  assign w_op_b  = (r_state == ST_REDUCE) ? ONE :
                   (r_state == ST_SQR)    ? r_acc : r_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rel      <= 1'b0;
      r_exp      <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_base     <= '0;
      r_err_pend <= 1'b0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_mul_en   <= 1'b0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_mul_n    <= '0;
    end else begin
      r_state    <= w_state_n;
      r_rel      <= w_rel_n;
      r_exp      <= w_exp_n;
      r_cnt      <= w_cnt_n;
      r_acc      <= w_acc_n;
      r_base     <= w_base_n;
      r_err_pend <= w_err_pend_n;
      r_result   <= w_result_n;
      r_done     <= w_done_n;
      r_busy     <= w_busy_n;
      r_err      <= w_err_n;
      r_mul_en   <= w_mul_en_n;
      r_mul_a    <= w_mul_a_n;
      r_mul_b    <= w_mul_b_n;
      r_mul_n    <= w_mul_n_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_rel_n      = r_rel;
    w_exp_n      = r_exp;
    w_cnt_n      = r_cnt;
    w_acc_n      = r_acc;
    w_base_n     = r_base;
    w_err_pend_n = r_err_pend;
    w_result_n   = r_result;
    w_done_n     = 1'b0;
    w_err_n      = r_err;
    w_mul_en_n   = r_mul_en;
    w_mul_a_n    = r_mul_a;
    w_mul_b_n    = r_mul_b;
    w_mul_n_n    = r_mul_n;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_exp_n      = exponent;
          w_base_n     = base;
          w_mul_n_n    = modulus;
          w_cnt_n      = CW'(EXP_WIDTH);
          w_rel_n      = 1'b0;
          w_err_n      = 1'b0;
          w_err_pend_n = 1'b0;
          if (modulus == '0) begin
            w_acc_n      = '0;
            w_err_pend_n = 1'b1;
            w_state_n    = ST_FIN;
          end else if (exponent == '0) begin
            w_acc_n   = (modulus == ONE) ? '0 : ONE;
            w_state_n = ST_FIN;
          end else begin
            w_state_n = ST_SCAN;
          end
        end
      end

      ST_SCAN: begin
        if (r_exp[EXP_WIDTH-1]) begin
          w_state_n = ST_REDUCE;
        end else begin
          w_exp_n = r_exp << 1;
          w_cnt_n = r_cnt - CW'(1);
        end
      end

      ST_NEXT: begin
        w_exp_n   = r_exp << 1;
        w_cnt_n   = r_cnt - CW'(1);
        w_state_n = (r_cnt == CW'(1)) ? ST_FIN : ST_SQR;
      end

      ST_FIN: begin
        w_result_n = r_acc;
        w_err_n    = r_err_pend;
        w_done_n   = 1'b1;
        w_state_n  = ST_DONE;
      end

      ST_DONE: w_state_n = ST_IDLE;

      default: ;
    endcase

    // Shared issue handshake: REQ (r_rel=0) then REL (r_rel=1) until valid drops.
    if (w_is_op) begin
      if (!r_rel) begin
        if (!r_mul_en) begin
          if (!mul_valid) begin
            w_mul_en_n = 1'b1;
            w_mul_a_n  = w_op_a;
            w_mul_b_n  = w_op_b;
          end
        end else if (mul_valid) begin
          w_mul_en_n = 1'b0;
          w_rel_n    = 1'b1;
          w_acc_n    = mul_r;
          if (r_state == ST_REDUCE) w_base_n = mul_r;
        end
      end else if (!mul_valid) begin
        w_rel_n = 1'b0;
        case (r_state)
          ST_REDUCE: begin
            w_exp_n   = r_exp << 1;
            w_cnt_n   = r_cnt - CW'(1);
            w_state_n = (r_cnt == CW'(1)) ? ST_FIN : ST_SQR;
          end
          ST_SQR:  w_state_n = r_exp[EXP_WIDTH-1] ? ST_MUL : ST_NEXT;
          default: w_state_n = ST_NEXT;
        endcase
      end
    end

    w_busy_n = (w_state_n != ST_IDLE);
  end

endmodule
